uart_frame_check_buf: RTL and testbench
=======================================

// Module: uart_frame_check_buf
// PURPOSE
//  Registered, parametrised UART receive-frame checker with a 1-entry output buffer.
//  - Takes the decoded frame fields from the RX deserialiser on a recieved_flag strobe.
//  - Checks parity, start and stop bits, buffers the data word with its error flags,
//    and hands both to the consumer over a valid/ready handshake.
//  - Keeps sticky status, including overrun, for the register interface.
// PARAMETERS
//  DATA_W     8   data bits per frame, legal 5..9
//  STOP_BITS  1   stop bits per frame, legal 1 or 2
//  CNT_W      16  width of each error counter (used only with UART_ERR_CNT_EN)
// PORTS
//  clock           in   1          rising-edge clock
//  reset_n         in   1          asynchronous active-low reset
//  recieved_flag   in   1          1-cycle strobe: frame fields below are valid
//  parity_type     in   2          00 none, 01 odd, 10 even, 11 none
//  raw_data        in   DATA_W     received data word
//  start_bit       in   1          sampled start bit, expected 0
//  parity_bit      in   1          sampled parity bit; ignored when parity is none
//  stop_bits       in   STOP_BITS  sampled stop bits, each expected 1
//  out_ready       in   1          consumer accepts the buffered entry
//  clear_status    in   1          1-cycle strobe: clear sticky flags and counters
//  out_valid       out  1          buffer holds an entry
//  out_data        out  DATA_W     buffered data word
//  error_flag      out  3          buffered errors {stop, start, parity}
//  sticky_flag     out  4          {overrun, stop, start, parity}, set until cleared
//  err_cnt_par     out  CNT_W      parity error count (only with macro)
//  err_cnt_start   out  CNT_W      start error count (only with macro)
//  err_cnt_stop    out  CNT_W      stop error count (only with macro)
// BEHAVIOUR
//  Reset: every output and internal register is 0; buffer state is EMPTY.
//  Checks, combinational on the inputs:
//  - par_err: odd mode -> ^{raw_data,parity_bit}==0; even mode -> ^{raw_data,parity_bit}==1.
//  - par_err is 0 for parity modes 00 and 11.
//  - start_err = start_bit. stop_err = ~&stop_bits.
//  Buffer FSM, states EMPTY and FULL:
//  - EMPTY + recieved_flag -> FULL. out_data and error_flag load at the same edge.
//    out_valid is high the next cycle (latency 1).
//  - FULL + out_ready + !recieved_flag -> EMPTY. out_valid drops the next cycle.
//  - FULL + out_ready + recieved_flag -> stay FULL, load the new frame, no overrun.
//  - FULL + !out_ready + recieved_flag -> new frame dropped, buffer unchanged,
//    sticky overrun bit set.
//  - out_data and error_flag are stable while out_valid && !out_ready.
//  - out_data and error_flag hold their last value when EMPTY.
//  Sticky flags:
//  - Each accepted frame ORs error_flag into sticky_flag[2:0].
//  - A dropped frame sets sticky_flag[3] only; its errors are not recorded.
//  - clear_status zeroes all sticky bits.
//  - clear_status in the same cycle as a set: the set wins, other bits clear.
//  - recieved_flag while reset_n is low is ignored.
//  - Reset mid-handshake empties the buffer immediately (asynchronous).
//  Width rules:
//  - parity is computed over DATA_W bits exactly.
//  - stop_bits[STOP_BITS-1:0] is checked in full; no bit is don't-care.
// CONFIGURATION
//  Macro UART_ERR_CNT_EN.
//  - Defined: three CNT_W-bit counters, each +1 per accepted frame with that error.
//    Counters saturate at all-ones and do not wrap.
//    clear_status with a same-cycle increment gives a count of 1.
//    Dropped frames are not counted.
//  - Undefined: no counter logic; err_cnt_* ports are present and tied to 0.
// TESTING
//  1. Reset low 3 cycles, then high -> all outputs 0, out_valid 0.
//  2. Even parity, raw_data=8'hA5, parity_bit=0, start=0, stop=1, strobe ->
//     next cycle out_valid=1, out_data=A5, error_flag=000.
//     Repeat with parity_bit=1 -> error_flag=001.
//  3. Mode 11, raw_data=8'h01, parity_bit=0, start=1, stop=0 -> error_flag=110,
//     sticky_flag=0110. Pulse clear_status -> sticky_flag=0000.
//  4. out_ready=0; frame 8'h11, then frame 8'h22 ->
//     out_data stays 11, sticky_flag[3]=1. Next, out_ready=1 with frame 8'h33 in the
//     same cycle -> out_data=33, out_valid stays 1.
//  5. STOP_BITS=2, DATA_W=7, odd parity, raw_data=7'h7F, parity_bit=0, stop_bits=2'b10 ->
//     error_flag=100.
//  6. UART_ERR_CNT_EN, CNT_W=2: five parity-error frames -> err_cnt_par=3 (saturated).
//     clear_status with a 6th parity-error frame -> err_cnt_par=1.

Source files
------------

// File: rtl/uart_frame_check_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_check_buf_if
// Brief    : Frame-in / checked-entry-out handshake and status bundle for
//            uart_frame_check_buf.
// Revision : 1.0
// ============================================================================
interface uart_frame_check_buf_if #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 16
);
  logic                 recieved_flag;
  logic [1:0]           parity_type;
  logic [DATA_W-1:0]    raw_data;
  logic                 start_bit;
  logic                 parity_bit;
  logic [STOP_BITS-1:0] stop_bits;
  logic                 out_ready;
  logic                 clear_status;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [2:0]           error_flag;
  logic [3:0]           sticky_flag;
  logic [CNT_W-1:0]     err_cnt_par;
  logic [CNT_W-1:0]     err_cnt_start;
  logic [CNT_W-1:0]     err_cnt_stop;

  modport master (
    output recieved_flag, parity_type, raw_data, start_bit, parity_bit,
           stop_bits, out_ready, clear_status,
    input  out_valid, out_data, error_flag, sticky_flag,
           err_cnt_par, err_cnt_start, err_cnt_stop
  );

  modport slave (
    input  recieved_flag, parity_type, raw_data, start_bit, parity_bit,
           stop_bits, out_ready, clear_status,
    output out_valid, out_data, error_flag, sticky_flag,
           err_cnt_par, err_cnt_start, err_cnt_stop
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_check_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_check_buf
// Brief    : UART RX frame checker (parity/start/stop) with a 1-entry
//            valid/ready output buffer and sticky status. Optional per-error
//            saturating counters under macro UART_ERR_CNT_EN.
// Revision : 1.0
// ============================================================================
module uart_frame_check_buf #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 16
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  uart_frame_check_buf_if.slave bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_err;
  logic [3:0]        r_sticky;

  logic       w_par_err;
  logic       w_start_err;
  logic       w_stop_err;
  logic [2:0] w_err;
  logic       w_accept;
  logic       w_drop;

  always_comb begin
    w_par_err = 1'b0;
    case (bus.parity_type)
      2'b01:   w_par_err = ~(^{bus.raw_data, bus.parity_bit});
      2'b10:   w_par_err =   ^{bus.raw_data, bus.parity_bit};
      default: w_par_err = 1'b0;
    endcase
  end

  assign w_start_err = bus.start_bit;
  assign w_stop_err  = ~(&bus.stop_bits);
  assign w_err       = {w_stop_err, w_start_err, w_par_err};

  // A full buffer only takes a new frame when the old one leaves this cycle.
  assign w_accept = bus.recieved_flag && ((r_state == EMPTY) || bus.out_ready);
  assign w_drop   = bus.recieved_flag && (r_state == FULL) && !bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   if (bus.recieved_flag) w_next = FULL;
      FULL:    if (bus.out_ready && !bus.recieved_flag) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_err    <= '0;
      r_sticky <= '0;
    end else begin
      if (w_accept) begin
        r_data <= bus.raw_data;
        r_err  <= w_err;
      end
      // Clear first, then OR in this cycle's events so a same-cycle set wins.
      r_sticky <= (bus.clear_status ? 4'b0000 : r_sticky)
                | {w_drop, (w_accept ? w_err : 3'b000)};
    end
  end

  assign bus.out_valid   = (r_state == FULL);
  assign bus.out_data    = r_data;
  assign bus.error_flag  = r_err;
  assign bus.sticky_flag = r_sticky;

`ifdef UART_ERR_CNT_EN
  logic [CNT_W-1:0] r_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_err_cnt
    logic [CNT_W-1:0] w_base;
    assign w_base = bus.clear_status ? '0 : r_cnt[g];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
        r_cnt[g] <= '0;
      else if (w_accept && w_err[g] && !(&w_base))
        r_cnt[g] <= w_base + 1'b1;
      else
        r_cnt[g] <= w_base;
    end
  end

  assign bus.err_cnt_par   = r_cnt[0];
  assign bus.err_cnt_start = r_cnt[1];
  assign bus.err_cnt_stop  = r_cnt[2];
`else
  assign bus.err_cnt_par   = '0;
  assign bus.err_cnt_start = '0;
  assign bus.err_cnt_stop  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_check_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_check_buf
// Brief    : Scoreboard bench: default-width DUT (a) and 7-bit/2-stop DUT (b).
// Revision : 1.0
// ============================================================================
module tb_uart_frame_check_buf;

  logic clk;
  logic rst_n;

  uart_frame_check_buf_if #(.DATA_W(8), .STOP_BITS(1), .CNT_W(16)) a_if ();
  uart_frame_check_buf_if #(.DATA_W(7), .STOP_BITS(2), .CNT_W(2))  b_if ();

  uart_frame_check_buf #(.DATA_W(8), .STOP_BITS(1), .CNT_W(16)) u_dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (a_if.slave)
  );

  uart_frame_check_buf #(.DATA_W(7), .STOP_BITS(2), .CNT_W(2)) u_dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b_if.slave)
  );

`ifdef UART_ERR_CNT_EN
  localparam int EXP_PAR_SAT  = 3;
  localparam int EXP_PAR_CLR  = 1;
  localparam int EXP_STOP_CNT = 2;
`else
  localparam int EXP_PAR_SAT  = 0;
  localparam int EXP_PAR_CLR  = 0;
  localparam int EXP_STOP_CNT = 0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [10:0] a_q [$];   // {data[7:0], err[2:0]}
  logic [9:0]  b_q [$];   // {data[6:0], err[2:0]}

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_if.out_valid && a_if.out_ready) begin
      if (a_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_entry: got %0h expected none", a_if.out_data);
      end else begin
        logic [10:0] e;
        e = a_q.pop_front();
        check("a_out_data",   {24'd0, a_if.out_data},   {24'd0, e[10:3]});
        check("a_error_flag", {29'd0, a_if.error_flag}, {29'd0, e[2:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.out_valid && b_if.out_ready) begin
      if (b_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_entry: got %0h expected none", b_if.out_data);
      end else begin
        logic [9:0] e;
        e = b_q.pop_front();
        check("b_out_data",   {25'd0, b_if.out_data},   {25'd0, e[9:3]});
        check("b_error_flag", {29'd0, b_if.error_flag}, {29'd0, e[2:0]});
      end
    end
  end

  // Drives one strobe cycle; accepted frames are pushed with their hand-computed errors.
  task automatic send_a(input logic [1:0] pt, input logic [7:0] d, input logic pb,
                        input logic sb, input logic stp, input logic clr,
                        input logic acc, input logic [2:0] exp_err);
    a_if.parity_type   = pt;
    a_if.raw_data      = d;
    a_if.parity_bit    = pb;
    a_if.start_bit     = sb;
    a_if.stop_bits     = stp;
    a_if.clear_status  = clr;
    a_if.recieved_flag = 1'b1;
    if (acc) a_q.push_back({d, exp_err});
    @(posedge clk); #1;
    a_if.recieved_flag = 1'b0;
    a_if.clear_status  = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] pt, input logic [6:0] d, input logic pb,
                        input logic [1:0] stp, input logic clr, input logic [2:0] exp_err);
    b_if.parity_type   = pt;
    b_if.raw_data      = d;
    b_if.parity_bit    = pb;
    b_if.start_bit     = 1'b0;
    b_if.stop_bits     = stp;
    b_if.clear_status  = clr;
    b_if.recieved_flag = 1'b1;
    b_q.push_back({d, exp_err});
    @(posedge clk); #1;
    b_if.recieved_flag = 1'b0;
    b_if.clear_status  = 1'b0;
  endtask

  task automatic pulse_clear_a();
    a_if.clear_status = 1'b1;
    @(posedge clk); #1;
    a_if.clear_status = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_if.recieved_flag = 1'b1;   // strobes during reset must be ignored
    a_if.parity_type = 2'b00; a_if.raw_data = 8'hFF; a_if.parity_bit = 1'b0;
    a_if.start_bit = 1'b1; a_if.stop_bits = 1'b0;
    a_if.out_ready = 1'b1; a_if.clear_status = 1'b0;
    b_if.recieved_flag = 1'b0; b_if.parity_type = 2'b00; b_if.raw_data = '0;
    b_if.parity_bit = 1'b0; b_if.start_bit = 1'b0; b_if.stop_bits = 2'b11;
    b_if.out_ready = 1'b1; b_if.clear_status = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_during", {31'd0, a_if.out_valid}, 32'd0);
    a_if.recieved_flag = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid",  {31'd0, a_if.out_valid},   32'd0);
    check("rst_data",   {24'd0, a_if.out_data},    32'd0);
    check("rst_err",    {29'd0, a_if.error_flag},  32'd0);
    check("rst_sticky", {28'd0, a_if.sticky_flag}, 32'd0);
    check("rst_cnt",    {16'd0, a_if.err_cnt_par}, 32'd0);

    // Even parity: A5 has four ones.
    send_a(2'b10, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    check("lat1_valid", {31'd0, a_if.out_valid}, 32'd1);
    send_a(2'b10, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
    check("sticky_par", {28'd0, a_if.sticky_flag}, 32'b0001);
    pulse_clear_a();
    check("sticky_clr0", {28'd0, a_if.sticky_flag}, 32'd0);

    // Mode 11 ignores parity; start and stop both wrong.
    send_a(2'b11, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110);
    check("sticky_0110", {28'd0, a_if.sticky_flag}, 32'b0110);
    pulse_clear_a();
    check("sticky_clr1", {28'd0, a_if.sticky_flag}, 32'd0);

    // Odd parity, 01 has one 1 -> pb=1 makes XOR 0 -> error; set beats clear.
    send_a(2'b01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
    send_a(2'b10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
    check("sticky_setwins", {28'd0, a_if.sticky_flag}, 32'b0010);
    @(posedge clk); #1;
    check("empty_after_drain", {31'd0, a_if.out_valid}, 32'd0);
    pulse_clear_a();

    // Stall: second frame dropped, its start error not recorded.
    a_if.out_ready = 1'b0;
    send_a(2'b00, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    send_a(2'b00, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010);
    check("stall_data",   {24'd0, a_if.out_data},    32'h11);
    check("stall_sticky", {28'd0, a_if.sticky_flag}, 32'b1000);
    @(posedge clk); #1;
    check("stall_hold",   {24'd0, a_if.out_data},    32'h11);
    a_if.out_ready = 1'b1;
    send_a(2'b00, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    check("swap_valid", {31'd0, a_if.out_valid}, 32'd1);
    check("swap_data",  {24'd0, a_if.out_data},  32'h33);
    @(posedge clk); #1;
    check("swap_drain", {31'd0, a_if.out_valid}, 32'd0);
    check("hold_empty", {24'd0, a_if.out_data},  32'h33);

    // DUT b: 7 data bits, 2 stop bits. 7F has seven ones.
    send_b(2'b01, 7'h7F, 1'b0, 2'b10, 1'b0, 3'b100);
    send_b(2'b01, 7'h7F, 1'b0, 2'b01, 1'b0, 3'b100);
    send_b(2'b10, 7'h7F, 1'b1, 2'b11, 1'b0, 3'b000);
    check("b_sticky", {28'd0, b_if.sticky_flag}, 32'b0100);
    for (int i = 0; i < 5; i++)
      send_b(2'b01, 7'h7F, 1'b1, 2'b11, 1'b0, 3'b001);
    check("b_cnt_sat",  {30'd0, b_if.err_cnt_par},  EXP_PAR_SAT);
    check("b_cnt_stop", {30'd0, b_if.err_cnt_stop}, EXP_STOP_CNT);
    send_b(2'b01, 7'h7F, 1'b1, 2'b11, 1'b1, 3'b001);
    check("b_cnt_clr",      {30'd0, b_if.err_cnt_par},  EXP_PAR_CLR);
    check("b_cnt_stop_clr", {30'd0, b_if.err_cnt_stop}, 32'd0);
    check("b_sticky_clr",   {28'd0, b_if.sticky_flag},  32'b0001);
    repeat (2) @(posedge clk); #1;
    check("a_queue_drained", a_q.size(), 32'd0);
    check("b_queue_drained", b_q.size(), 32'd0);

    // Asynchronous reset while an entry is stalled.
    a_if.out_ready = 1'b0;
    send_a(2'b00, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, a_if.out_valid}, 32'd0);
    check("async_rst_data",  {24'd0, a_if.out_data},  32'd0);
    a_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
